// File: rtl/nt_stim_driver.sv
// nt_stim_driver
//   Driving end of an Nt-node detection path. A test vector, its hold length
//   and the expected single-bit response are accepted over a valid/ready
//   handshake. The vector is driven onto the subcircuit inputs for the hold
//   length, kept there while the subcircuit's sequential latency elapses, and
//   then the subcircuit response is sampled and compared. Mismatches are
//   accumulated in a saturating counter.
//
// Ports
//   I1470      clock, rising edge
//   I1477      asynchronous active-high reset
//   in_valid   stimulus request valid
//   in_ready   driver can accept a request (IDLE and not in reset)
//   in_vec     stimulus vector
//   in_hold    drive length in cycles (0 behaves as 1)
//   in_exp     expected response bit
//   dut_vec    vector driven to the subcircuit inputs
//   dut_resp   subcircuit response bit, synchronous to I1470
//   res_valid  one-cycle result strobe
//   res_match  response equals expectation (0 whenever res_valid is 0)
//   mis_cnt    saturating mismatch count since reset
//   busy       high in every state except IDLE
module nt_stim_driver #(
  parameter int VEC_W  = 7,
  parameter int HOLD_W = 4,
  parameter int LAT    = 2,
  parameter int CNT_W  = 8
) (
  input  logic              I1470,
  input  logic              I1477,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vec,
  input  logic [HOLD_W-1:0] in_hold,
  input  logic              in_exp,
  output logic [VEC_W-1:0]  dut_vec,
  input  logic              dut_resp,
  output logic              res_valid,
  output logic              res_match,
  output logic [CNT_W-1:0]  mis_cnt,
  output logic              busy
);

  // The latency counter is 4 bits wide, so LAT must fit 1..15.
  generate
    if (LAT < 1 || LAT > 15) begin : g_lat_range
      $error("nt_stim_driver: LAT must be in 1..15");
    end
  endgenerate

  localparam int LCNT_W = 4;
  localparam logic [LCNT_W-1:0] LAT_V = LCNT_W'(LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [VEC_W-1:0]    vec_n;
  logic                exp_r, exp_n;
  logic [HOLD_W-1:0]   hcnt, hcnt_n;
  logic [LCNT_W-1:0]   lcnt, lcnt_n;
  logic                rv_n, rm_n;
  logic [CNT_W-1:0]    cnt_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Ready is gated by reset directly so it drops while reset is held and
  // rises as soon as reset is released with the FSM sitting in IDLE.
  assign in_ready = (state == S_IDLE) && !I1477;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge I1470 or posedge I1477) begin
    if (I1477) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge I1470 or posedge I1477) begin
    if (I1477) begin
      dut_vec   <= '0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      mis_cnt   <= '0;
    end else begin
      dut_vec   <= vec_n;
      res_valid <= rv_n;
      res_match <= rm_n;
      mis_cnt   <= cnt_n;
    end
  end

  // Working registers are only meaningful once loaded by the FSM.
  always_ff @(posedge I1470) begin
    exp_r <= exp_n;
    hcnt  <= hcnt_n;
    lcnt  <= lcnt_n;
  end

  always_comb begin
    state_n = state;
    vec_n   = dut_vec;
    exp_n   = exp_r;
    hcnt_n  = hcnt;
    lcnt_n  = lcnt;
    rv_n    = 1'b0;
    rm_n    = 1'b0;
    cnt_n   = mis_cnt;
    unique case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          vec_n   = in_vec;
          exp_n   = in_exp;
          hcnt_n  = (in_hold == '0) ? HOLD_W'(1) : in_hold;
          state_n = S_DRIVE;
        end
      end
      S_DRIVE: begin
        hcnt_n = hcnt - 1'b1;
        if (hcnt == HOLD_W'(1)) begin
          lcnt_n  = LAT_V;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        lcnt_n = lcnt - 1'b1;
        if (lcnt == LCNT_W'(1)) begin
          rv_n    = 1'b1;
          rm_n    = (dut_resp == exp_r);
          vec_n   = '0;
          if (dut_resp != exp_r) begin
            cnt_n = sat_inc(mis_cnt);
          end
          state_n = S_REPORT;
        end
      end
      S_REPORT: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nt_stim_driver.sv
module tb_nt_stim_driver;

  localparam int VEC_W  = 7;
  localparam int HOLD_W = 4;
  localparam int LAT    = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [VEC_W-1:0]  in_vec = '0;
  logic [HOLD_W-1:0] in_hold = '0;
  logic              in_exp = 1'b0;
  logic [VEC_W-1:0]  dut_vec;
  logic              dut_resp = 1'b0;
  logic              res_valid;
  logic              res_match;
  logic [CNT_W-1:0]  mis_cnt;
  logic              busy;

  nt_stim_driver #(.VEC_W(VEC_W), .HOLD_W(HOLD_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .I1470    (clk),
    .I1477    (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .in_hold  (in_hold),
    .in_exp   (in_exp),
    .dut_vec  (dut_vec),
    .dut_resp (dut_resp),
    .res_valid(res_valid),
    .res_match(res_match),
    .mis_cnt  (mis_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit   match;
    int   cnt;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   acc_cnt = 0;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  // Monitor: pops the scoreboard whenever a result is strobed.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_vs_ready", int'(busy), int'(!in_ready));
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_match", int'(res_match), int'(e.match));
          chk("mis_cnt_at_res", int'(mis_cnt), e.cnt);
          chk("res_cycle", cyc, e.cyc);
        end
      end else begin
        chk("res_match_idle", int'(res_match), 0);
      end
    end
  end

  task automatic send(input logic [6:0] v, input logic [3:0] h, input logic e,
                      input logic r, input bit keep, output int acc);
    int   w;
    int   heff;
    exp_t x;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      acc = -1;
      return;
    end
    in_valid = 1'b1;
    in_vec   = v;
    in_hold  = h;
    in_exp   = e;
    dut_resp = r;
    heff = (h == 4'd0) ? 1 : int'(h);
    if (r != e && model_cnt < 255) model_cnt++;
    x.match = (r == e);
    x.cnt   = model_cnt;
    x.cyc   = cyc + 1 + heff + LAT;
    sb.push_back(x);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    chk("dut_vec_latch", int'(dut_vec), int'(v));
    chk("ready_low_after_accept", int'(in_ready), 0);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, acc_start;

    // Reset state
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dut_vec", int'(dut_vec), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_match", int'(res_match), 0);
    chk("rst_mis_cnt", int'(mis_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_rst", int'(in_ready), 1);

    // Basic match: hold 3, LAT 2
    send(7'h5A, 4'd3, 1'b1, 1'b1, 1'b0, a0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("basic_dut_vec_hold", int'(dut_vec), 'h5A);
    end
    @(negedge clk);
    chk("basic_res_valid", int'(res_valid), 1);
    chk("basic_res_match", int'(res_match), 1);
    chk("basic_mis_cnt", int'(mis_cnt), 0);
    chk("basic_dut_vec_clear", int'(dut_vec), 0);
    @(negedge clk);
    chk("basic_ready_back", int'(in_ready), 1);
    chk("basic_res_valid_one_cycle", int'(res_valid), 0);

    // Mismatch
    send(7'h5A, 4'd3, 1'b1, 1'b0, 1'b0, a0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mis_dut_vec_hold", int'(dut_vec), 'h5A);
    end
    @(negedge clk);
    chk("mis_res_valid", int'(res_valid), 1);
    chk("mis_res_match", int'(res_match), 0);
    chk("mis_mis_cnt", int'(mis_cnt), 1);
    chk("mis_dut_vec_clear", int'(dut_vec), 0);
    drain();

    // Zero hold behaves as hold 1
    send(7'h7F, 4'd0, 1'b1, 1'b1, 1'b0, a0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zh_dut_vec_hold", int'(dut_vec), 'h7F);
    end
    @(negedge clk);
    chk("zh_res_valid", int'(res_valid), 1);
    chk("zh_dut_vec_clear", int'(dut_vec), 0);
    drain();

    // Back-to-back with in_valid held high; middle vector expects a mismatch
    acc_start = acc_cnt;
    send(7'h01, 4'd1, 1'b1, 1'b1, 1'b1, a0);
    send(7'h02, 4'd1, 1'b0, 1'b1, 1'b1, a1);
    send(7'h04, 4'd1, 1'b1, 1'b1, 1'b0, a2);
    chk("b2b_spacing_1", a1 - a0, 5);
    chk("b2b_spacing_2", a2 - a1, 5);
    drain();
    chk("b2b_accept_count", acc_cnt - acc_start, 3);
    chk("b2b_mis_cnt", int'(mis_cnt), 2);

    // Reset in WAIT after two mismatches
    send(7'h11, 4'd1, 1'b1, 1'b0, 1'b0, a0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_dut_vec", int'(dut_vec), 'h11);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_dut_vec", int'(dut_vec), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(in_ready), 0);
    chk("async_rst_mis_cnt", int'(mis_cnt), 0);
    chk("async_rst_res_valid", int'(res_valid), 0);
    sb.delete();
    model_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_mid_rst", int'(in_ready), 1);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("mis_cnt_after_mid_rst", int'(mis_cnt), 0);

    // Saturation
    for (int i = 0; i < 256; i++) begin
      logic [6:0] v;
      v = 7'(i);
      send(v, 4'd1, 1'b1, 1'b0, 1'b0, a0);
    end
    drain();
    chk("sat_reach_255", int'(mis_cnt), 255);
    send(7'h33, 4'd1, 1'b0, 1'b1, 1'b0, a0);
    drain();
    chk("sat_hold_255", int'(mis_cnt), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
